// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmit engine.
package uart_tx_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_calc(input logic [DATA_W_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: counts CLKS_PER_BIT clocks and flags the last one of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || bit_done) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit engine: holding register, frame FSM and registered serial line.
// Define UART_TX_BREAK_EN to build the line-break state driven by brk.
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    input  logic              brk,
    output logic              tx_out,
    output logic              tx_busy
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_par_en_q, hold_par_en_d;
    logic              hold_par_odd_q, hold_par_odd_d;
    logic              hold_two_stop_q, hold_two_stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              two_stop_q, two_stop_d;
    logic              brk_mark_q, brk_mark_d;
    logic              tx_out_q, tx_out_d;
    logic              accept, load, bit_done, baud_restart;

`ifdef UART_TX_BREAK_EN
    // Refuse words while a break is requested or running so BREAK always starts with holding empty.
    assign tx_ready     = !hold_full_q && (state_q != BREAK) && !((state_q == IDLE) && brk);
    assign baud_restart = (state_q == IDLE) || ((state_q == BREAK) && !brk_mark_q);
`else
    logic brk_unused;
    assign brk_unused   = brk;
    assign tx_ready     = !hold_full_q;
    assign baud_restart = (state_q == IDLE);
`endif

    assign accept  = tx_valid && tx_ready;
    assign tx_out  = tx_out_q;
    assign tx_busy = (state_q != IDLE) || hold_full_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (baud_restart),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d         = state_q;
        hold_full_d     = hold_full_q;
        hold_data_d     = hold_data_q;
        hold_par_en_d   = hold_par_en_q;
        hold_par_odd_d  = hold_par_odd_q;
        hold_two_stop_d = hold_two_stop_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        stop_cnt_d      = stop_cnt_q;
        par_en_d        = par_en_q;
        par_bit_d       = par_bit_q;
        two_stop_d      = two_stop_q;
        brk_mark_d      = brk_mark_q;
        load            = 1'b0;

        if (accept) begin
            hold_full_d     = 1'b1;
            hold_data_d     = tx_data;
            hold_par_en_d   = parity_en;
            hold_par_odd_d  = parity_odd;
            hold_two_stop_d = two_stop;
        end

        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (brk && !hold_full_q) state_d = BREAK;
                else
`endif
                if (hold_full_q) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (hold_full_q) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                // Line held low until brk drops, then one full bit of mark before leaving.
                if (!brk_mark_q) begin
                    if (!brk) brk_mark_d = 1'b1;
                end else if (bit_done) begin
                    brk_mark_d = 1'b0;
                    state_d    = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (load) begin
            hold_full_d = 1'b0;
            shift_d     = hold_data_q;
            par_en_d    = hold_par_en_q;
            par_bit_d   = parity_calc(DATA_W_MAX'(hold_data_q), hold_par_odd_q);
            two_stop_d  = hold_two_stop_q;
        end
    end

    // Line value is decoded from next state so tx_out changes on the same edge as the FSM.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = par_bit_d;
            BREAK:   tx_out_d = brk_mark_d;
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            hold_full_q     <= 1'b0;
            hold_data_q     <= '0;
            hold_par_en_q   <= 1'b0;
            hold_par_odd_q  <= 1'b0;
            hold_two_stop_q <= 1'b0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            stop_cnt_q      <= 1'b0;
            par_en_q        <= 1'b0;
            par_bit_q       <= 1'b0;
            two_stop_q      <= 1'b0;
            brk_mark_q      <= 1'b0;
            tx_out_q        <= 1'b1;
        end else begin
            state_q         <= state_d;
            hold_full_q     <= hold_full_d;
            hold_data_q     <= hold_data_d;
            hold_par_en_q   <= hold_par_en_d;
            hold_par_odd_q  <= hold_par_odd_d;
            hold_two_stop_q <= hold_two_stop_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            stop_cnt_q      <= stop_cnt_d;
            par_en_q        <= par_en_d;
            par_bit_q       <= par_bit_d;
            two_stop_q      <= two_stop_d;
            brk_mark_q      <= brk_mark_d;
            tx_out_q        <= tx_out_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench: each accepted word queues its expected frame; a monitor checks the line every cycle.
module tb_uart_tx_frame_gen;

    localparam int DW = 8;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid, tx_ready, parity_en, parity_odd, two_stop, brk, tx_out, tx_busy;
    logic [DW-1:0] tx_data;
    logic          v5, r5, out5, busy5;
    logic [4:0]    d5;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint last_end = 0;
    bit     mon_off  = 1'b1;

    typedef struct {
        longint      acc;
        longint      start;
        int          nb;
        logic [15:0] bits;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame_gen #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop), .brk(brk),
        .tx_out(tx_out), .tx_busy(tx_busy)
    );

    uart_tx_frame_gen #(.DATA_W(5), .CLKS_PER_BIT(2)) dut5 (
        .clk(clk), .rst(rst), .tx_valid(v5), .tx_ready(r5), .tx_data(d5),
        .parity_en(1'b0), .parity_odd(1'b0), .two_stop(1'b0), .brk(1'b0),
        .tx_out(out5), .tx_busy(busy5)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, 1 or 2 stop bits.
    function automatic exp_t build(input logic [DW-1:0] d, input logic pe, po, ts);
        exp_t e;
        logic p;
        e.bits = '0;
        e.nb   = 1;
        p      = po;
        for (int i = 0; i < DW; i++) begin
            e.bits[e.nb] = d[i];
            p            = p ^ d[i];
            e.nb++;
        end
        if (pe) begin
            e.bits[e.nb] = p;
            e.nb++;
        end
        e.bits[e.nb] = 1'b1;
        e.nb += ts ? 2 : 1;
        if (ts) e.bits[e.nb-1] = 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin
        logic exp_o, exp_b, exp_r;
        bit   pop;
        if (!mon_off) begin
            exp_o = 1'b1;
            pop   = 1'b0;
            if (sb.size() > 0 && cyc >= sb[0].start) begin
                exp_o = sb[0].bits[int'((cyc - sb[0].start) / C)];
                pop   = (cyc == sb[0].start + sb[0].nb * C - 1);
            end
            exp_b = (sb.size() > 0 && cyc >= sb[0].acc);
            exp_r = !(sb.size() > 0 && cyc >= sb[$].acc && cyc < sb[$].start);
            chk("tx_out", tx_out, exp_o);
            chk("tx_busy", tx_busy, exp_b);
            chk("tx_ready", tx_ready, exp_r);
            if (pop) void'(sb.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [DW-1:0] d, input logic pe, po, ts);
        exp_t e;
        int   guard = 0;
        tx_valid   = 1'b1;
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        forever begin
            @(negedge clk);
            if (tx_ready) break;
            guard++;
            if (guard > 300) begin
                failures++;
                $display("FAIL accept_timeout cyc=%0d actual=no_ready expected=ready", cyc);
                tx_valid = 1'b0;
                return;
            end
        end
        e       = build(d, pe, po, ts);
        e.acc   = cyc + 1;
        e.start = (e.acc + 1 > last_end) ? e.acc + 1 : last_end;
        last_end = e.start + e.nb * C;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tx_valid   = 1'b0;
        tx_data    = DW'($urandom);
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        two_stop   = 1'($urandom);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 3000) begin
                failures++;
                $display("FAIL drain_timeout cyc=%0d actual=%0d_pending expected=0", cyc, sb.size());
                sb.delete();
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint target, acc5;
        int     hi, guard;
        bit     got_start;
        rst = 1'b0; tx_valid = 1'b0; tx_data = '0; parity_en = 1'b0; parity_odd = 1'b0;
        two_stop = 1'b0; brk = 1'b0; v5 = 1'b0; d5 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_out", tx_out, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_out5", out5, 1'b1);
        rst = 1'b1;
        mon_off = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_drain();
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_drain();
        send(8'h00, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0, 1'b0);
        wait_drain();

        for (int n = 0; n < 60; n++) begin
            send(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(0, 70)) @(posedge clk);
                #1;
            end
        end
        wait_drain();

        // Reset in the middle of DATA with a second word already waiting in holding.
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        send(DW'($urandom), 1'b1, 1'b0, 1'b1);
        target = sb[0].start + 3 * C;
        guard  = 0;
        while (cyc < target && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        #2;
        mon_off = 1'b1;
        rst = 1'b0;
        #1;
        chk("midrst_tx_out", tx_out, 1'b1);
        chk("midrst_tx_ready", tx_ready, 1'b1);
        chk("midrst_tx_busy", tx_busy, 1'b0);
        sb.delete();
        last_end = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_off = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        // DATA_W=5, CLKS_PER_BIT=2 instance: 7 bits of 2 cycles each.
        v5 = 1'b1;
        d5 = 5'h1F;
        @(negedge clk);
        chk("w5_ready", r5, 1'b1);
        acc5 = cyc + 1;
        @(posedge clk);
        #1;
        v5 = 1'b0;
        @(negedge clk);
        chk("w5_hold_line", out5, 1'b1);
        chk("w5_hold_busy", busy5, 1'b1);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            chk("w5_tx_out", out5, (j < 2) ? 1'b0 : 1'b1);
            chk("w5_busy", busy5, 1'b1);
        end
        @(negedge clk);
        chk("w5_end_busy", busy5, 1'b0);
        chk("w5_end_line", out5, 1'b1);
        if (cyc != acc5 + 15) begin
            failures++;
            $display("FAIL w5_timing actual=%0d expected=%0d", cyc, acc5 + 15);
        end

`ifdef UART_TX_BREAK_EN
        @(posedge clk);
        #1;
        mon_off = 1'b1;
        brk = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("brk_low", tx_out, 1'b0);
            chk("brk_ready", tx_ready, 1'b0);
        end
        brk = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h55;
        parity_en = 1'b0;
        two_stop = 1'b0;
        hi = 0;
        got_start = 1'b0;
        for (int j = 0; j < 30 && !got_start; j++) begin
            @(negedge clk);
            if (tx_ready) tx_valid = 1'b0;
            if (tx_out) hi++;
            else got_start = 1'b1;
        end
        tx_valid = 1'b0;
        chk("brk_mark_then_start", (hi >= C) && got_start, 1'b1);
`else
        hi = 0;
        got_start = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
